// File: rtl/mp3_time_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_time_pkg
//  Description : Shared BCD time types and constants for the mm:ss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package mp3_time_pkg;

    localparam int BCD_W            = 4;
    localparam int TICK_DIV_DEFAULT = 100_000_000;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t min_h;
        bcd_t min_l;
        bcd_t sec_h;
        bcd_t sec_l;
    } mmss_t;

    localparam bcd_t DIG_MAX   = 4'd9;
    localparam bcd_t SEC_H_MAX = 4'd5;

    function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmss_countdown_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Enabled prescaler producing a one-cycle tick every TICK_DIV
//                enabled cycles; sync clear, holds its count while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            c_CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);
    assign tick   = en & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmss_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_countdown
//  Description : Loadable mm:ss BCD remaining-time counter, decremented once
//                per second down to 00:00 with a one-cycle expiry pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmss_countdown
    import mp3_time_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] ld_min_h,
    input  logic [3:0] ld_min_l,
    input  logic [3:0] ld_sec_h,
    input  logic [3:0] ld_sec_l,
    input  logic       run,
    output logic [3:0] min_h,
    output logic [3:0] min_l,
    output logic [3:0] sec_h,
    output logic [3:0] sec_l,
    output logic       zero,
    output logic       expired
);

    mmss_t r_time;
    logic  r_expired;
    mmss_t w_ld;
    mmss_t w_dec;
    logic  w_tick;
    logic  w_en;

    assign zero    = (r_time == '0);
    assign expired = r_expired;
    assign min_h   = r_time.min_h;
    assign min_l   = r_time.min_l;
    assign sec_h   = r_time.sec_h;
    assign sec_l   = r_time.sec_l;

    // Prescaler only advances while counting, so reaching 00:00 freezes it at 0.
    assign w_en = run & ~zero;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .clr   (load),
        .tick  (w_tick)
    );

    always_comb begin
        w_ld.min_h = bcd_clamp(ld_min_h, DIG_MAX);
        w_ld.min_l = bcd_clamp(ld_min_l, DIG_MAX);
        w_ld.sec_h = bcd_clamp(ld_sec_h, SEC_H_MAX);
        w_ld.sec_l = bcd_clamp(ld_sec_l, DIG_MAX);
    end

    // Single-cycle borrow chain; min_h never underflows because zero gates the tick.
    always_comb begin
        w_dec = r_time;
        if (r_time.sec_l != '0) begin
            w_dec.sec_l = r_time.sec_l - 4'd1;
        end else begin
            w_dec.sec_l = DIG_MAX;
            if (r_time.sec_h != '0) begin
                w_dec.sec_h = r_time.sec_h - 4'd1;
            end else begin
                w_dec.sec_h = SEC_H_MAX;
                if (r_time.min_l != '0) begin
                    w_dec.min_l = r_time.min_l - 4'd1;
                end else begin
                    w_dec.min_l = DIG_MAX;
                    w_dec.min_h = r_time.min_h - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time    <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (load) begin
                r_time <= w_ld;
            end else if (w_tick) begin
                r_time    <= w_dec;
                r_expired <= (w_dec == '0);
            end
        end
    end

endmodule
`default_nettype wire
